// File: rtl/bt_pipe_pkg.sv
// Shared types and constants for the block-throttled pipe initiator.
// The pattern helpers here are the same ones the pipe checkers use.
package bt_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_STROBE   = 3'd2,
    ST_BURST    = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LFSR_W = 32;
  // Taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [WORD_W-1:0] CNT_START = 16'h0001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// Pattern source shared by both directions: a Fibonacci LFSR and a
// wrapping counter, both restarted by load and stepped once per strobe.
module pipe_pattern_gen
  import bt_pipe_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  output logic [WORD_W-1:0] word
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;

  // Load wins over advance so a new transfer always starts from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      lfsr_d = SEED;
      cnt_d  = CNT_START;
    end else if (advance) begin
      lfsr_d = lfsr_next(lfsr_q);
      cnt_d  = cnt_q + 16'd1;
    end else begin
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
      cnt_q  <= 16'h0000;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = mode ? cnt_q : lfsr_q[WORD_W-1:0];

endmodule

// File: rtl/bt_pipe_initiator.sv
// Block-throttled pipe initiator: writes pattern data to a pipe-in consumer
// or drains a pipe-out producer and counts mismatches against the pattern.
module bt_pipe_initiator
  import bt_pipe_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 64,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        dir,
  input  logic        mode,
  input  logic [15:0] num_blocks,
  output logic        busy,
  output logic        done,
  output logic [15:0] error_count,
  output logic        block_strobe,
  output logic        wr_write,
  output logic [15:0] wr_data,
  input  logic        wr_ready,
  output logic        rd_read,
  input  logic [15:0] rd_data,
  input  logic        rd_valid
);

  localparam int unsigned WCNT_W = $clog2(BLOCK_LEN);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BLOCK_LEN - 1);

  state_e            state_q, state_d;
  logic [15:0]       blk_q, blk_d;
  logic [WCNT_W-1:0] word_q, word_d;
  logic              dir_q, dir_d;
  logic              mode_q, mode_d;
  logic [15:0]       err_q, err_d;
  logic [15:0]       exp_q;
  logic              chk_q;
  logic              busy_q, done_q, strobe_q, wr_write_q, rd_read_q;
  logic              load_s;
  logic              advance_s;
  logic [15:0]       pat_word_s;

  assign advance_s = wr_write_q | rd_read_q;

  pipe_pattern_gen #(
    .SEED(SEED)
  ) u_pattern (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load_s),
    .advance(advance_s),
    .mode   (mode_q),
    .word   (pat_word_s)
  );

  // Transfer sequencing; dir/mode/num_blocks are captured only on an accepted start.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    word_d  = word_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = dir;
          mode_d  = mode;
          blk_d   = num_blocks;
          word_d  = '0;
          load_s  = 1'b1;
          state_d = (num_blocks == 16'd0) ? ST_DONE : ST_WAIT_RDY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        if (dir_q ? rd_valid : wr_ready) begin
          state_d = ST_STROBE;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_STROBE: begin
        word_d  = '0;
        state_d = ST_BURST;
      end
      ST_BURST: begin
        if (word_q == LAST_WORD) begin
          word_d = '0;
          blk_d  = blk_q - 16'd1;
          if (blk_q > 16'd1) begin
            state_d = ST_WAIT_RDY;
          end else if (dir_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          word_d = word_q + WCNT_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Mismatch counter: compares the word returned one cycle after each read strobe.
  always_comb begin
    err_d = err_q;
    if (load_s) begin
      err_d = 16'h0000;
    end else if (chk_q && (rd_data != exp_q) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State, counters and registered outputs (outputs decoded from next state).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      blk_q      <= 16'h0000;
      word_q     <= '0;
      dir_q      <= 1'b0;
      mode_q     <= 1'b0;
      err_q      <= 16'h0000;
      exp_q      <= 16'h0000;
      chk_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
      wr_write_q <= 1'b0;
      rd_read_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      word_q     <= word_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      exp_q      <= rd_read_q ? pat_word_s : exp_q;
      chk_q      <= rd_read_q;
      busy_q     <= (state_d == ST_WAIT_RDY) || (state_d == ST_STROBE) ||
                    (state_d == ST_BURST) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
      strobe_q   <= (state_d == ST_STROBE);
      wr_write_q <= (state_d == ST_BURST) && !dir_d;
      rd_read_q  <= (state_d == ST_BURST) && dir_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign block_strobe = strobe_q;
  assign wr_write     = wr_write_q;
  assign wr_data      = wr_write_q ? pat_word_s : 16'h0000;
  assign rd_read      = rd_read_q;
  assign error_count  = err_q;

endmodule

// File: tb/tb_bt_pipe_initiator.sv
// Scoreboard bench for bt_pipe_initiator: a driver queues expected words and
// completions from a pattern model, a monitor checks them as the DUT emits them.
module tb_bt_pipe_initiator;

  localparam int          BL   = 4;
  localparam logic [31:0] SEED = 32'h1234_ACE1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_blocks = 16'd0;
  logic        busy, done, block_strobe, wr_write, rd_read;
  logic [15:0] error_count, wr_data;
  logic        wr_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = 16'h0000;

  bt_pipe_initiator #(.BLOCK_LEN(BL), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .mode(mode),
    .num_blocks(num_blocks), .busy(busy), .done(done), .error_count(error_count),
    .block_strobe(block_strobe), .wr_write(wr_write), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_read(rd_read), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int err;
    bit rd;
    int nb;
    int start_cyc;
  } done_t;

  logic [15:0] exp_wr[$];
  logic [15:0] rd_model[$];
  done_t       exp_done[$];
  int exp_rd = 0;
  int exp_blk = 0;
  int done_cnt = 0;
  int last_strobe_cyc = 0;
  int start_cyc = 0;
  bit first_pending = 0;
  bit cur_dir = 0;
  bit rdy_prev = 0;
  int rdy_mode = 0;
  int rd_idx = 0;
  int corrupt_idx = -1;
  logic [15:0] corrupt_mask = 16'h0000;

  // Reference pattern: the spec's LFSR polynomial taps at powers 32, 22, 2, 1.
  function automatic logic [31:0] model_lfsr_step(input logic [31:0] x);
    logic fb;
    fb = x[31] ^ x[21] ^ x[1] ^ x[0];
    return {x[30:0], fb};
  endfunction

  // Ready inputs change just after the rising edge, so they are stable when sampled.
  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        wr_ready = 1'b1;
        rd_valid = 1'b1;
      end else begin
        wr_ready = ($urandom_range(0, 2) == 0);
        rd_valid = ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Pipe-out producer model: returns the next pattern word one cycle after rd_read.
  initial begin : responder
    bit hit;
    logic [15:0] v;
    forever begin
      @(negedge clk);
      hit = reset_n && rd_read;
      v = 16'h0000;
      if (hit) begin
        v = (rd_model.size() > 0) ? rd_model.pop_front() : 16'hDEAD;
        if (rd_idx == corrupt_idx) v = v ^ corrupt_mask;
        rd_idx++;
      end
      @(posedge clk);
      #1;
      if (hit) rd_data = v;
    end
  end

  initial begin : monitor
    done_t d;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (block_strobe) begin
          check("strobe_needs_ready", {31'd0, rdy_prev}, 32'd1);
          check("strobe_expected", {31'd0, exp_blk > 0}, 32'd1);
          if (first_pending && rdy_mode == 0) check("first_strobe_cycle", cyc - start_cyc, 32'd2);
          first_pending = 0;
          if (exp_blk > 0) exp_blk--;
        end
        if (wr_write) begin
          check("wr_write_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
          if (exp_wr.size() > 0) check("wr_data", {16'd0, wr_data}, {16'd0, exp_wr.pop_front()});
          last_strobe_cyc = cyc;
        end
        if (rd_read) begin
          check("rd_read_expected", {31'd0, exp_rd > 0}, 32'd1);
          if (exp_rd > 0) exp_rd--;
          last_strobe_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          check("done_expected", {31'd0, exp_done.size() > 0}, 32'd1);
          if (exp_done.size() > 0) begin
            d = exp_done.pop_front();
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
            check("error_count", {16'd0, error_count}, d.err);
            check("words_left", exp_wr.size() + exp_rd, 32'd0);
            check("blocks_left", exp_blk, 32'd0);
            if (d.nb == 0) check("empty_done_latency", cyc - d.start_cyc, 32'd1);
            else check("done_latency", cyc - last_strobe_cyc, d.rd ? 32'd2 : 32'd1);
          end
        end
      end
      rdy_prev = cur_dir ? rd_valid : wr_ready;
    end
  end

  task automatic launch(input bit d, input bit m, input int nb, input int rmode,
                        input int cidx, input logic [15:0] cmask, input bit extra);
    logic [31:0] l;
    logic [15:0] w;
    done_t e;
    l = SEED;
    for (int k = 0; k < nb * BL; k++) begin
      w = m ? 16'(k + 1) : l[15:0];
      l = model_lfsr_step(l);
      if (d) rd_model.push_back(w);
      else exp_wr.push_back(w);
    end
    @(negedge clk);
    rdy_mode = rmode;
    @(negedge clk);
    exp_rd = d ? nb * BL : 0;
    exp_blk = nb;
    rd_idx = 0;
    corrupt_idx = (d && nb > 0) ? cidx : -1;
    corrupt_mask = cmask;
    e.err = (d && nb > 0 && cidx >= 0 && cidx < nb * BL) ? 1 : 0;
    e.rd = d;
    e.nb = nb;
    e.start_cyc = cyc;
    exp_done.push_back(e);
    start_cyc = cyc;
    first_pending = 1;
    cur_dir = d;
    start = 1'b1;
    dir = d;
    mode = m;
    num_blocks = 16'(nb);
    @(negedge clk);
    start = 1'b0;
    dir = 1'($urandom);
    mode = 1'($urandom);
    num_blocks = 16'($urandom_range(0, 9));
    if (extra) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        start = 1'b1;
        num_blocks = 16'($urandom_range(0, 9));
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int n0);
    int t;
    t = 0;
    while (done_cnt == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, done_cnt != n0}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input bit d, input bit m, input int nb, input int rmode,
                     input int cidx, input logic [15:0] cmask, input bit extra);
    int n0;
    n0 = done_cnt;
    launch(d, m, nb, rmode, cidx, cmask, extra);
    wait_done(n0);
  endtask

  initial begin : driver
    int t;
    int n0;
    int nb;
    bit d;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'd0, busy, done, block_strobe, wr_write, rd_read}, 32'd0);
    check("reset_err", {16'd0, error_count}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(1'b0, 1'b1, 2, 0, -1, 16'h0000, 1'b0);           // counter write, basic
    run(1'b0, 1'b1, 2, 1, -1, 16'h0000, 1'b0);           // throttled write
    run(1'b1, 1'b0, 2, 0, 2, 16'h0001, 1'b0);            // LFSR read, word 3 corrupted
    run(1'b1, 1'b0, 2, 1, -1, 16'h0000, 1'b0);           // clean read clears count
    run(1'b0, 1'b0, 0, 0, -1, 16'h0000, 1'b0);           // empty write
    run(1'b1, 1'b1, 0, 0, -1, 16'h0000, 1'b0);           // empty read
    run(1'b0, 1'b0, 3, 0, -1, 16'h0000, 1'b1);           // start while busy

    // Reset in the middle of a burst, then restart from the seed.
    launch(1'b0, 1'b0, 2, 0, -1, 16'h0000, 1'b0);
    t = 0;
    while (exp_wr.size() > 2 * BL - 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", {27'd0, busy, done, block_strobe, wr_write, rd_read}, 32'd0);
    check("midreset_data", {16'd0, wr_data}, 32'd0);
    exp_wr.delete();
    rd_model.delete();
    exp_done.delete();
    exp_blk = 0;
    exp_rd = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b0, 1'b0, 1, 0, -1, 16'h0000, 1'b0);

    // Randomised transfers.
    for (int i = 0; i < 14; i++) begin
      nb = $urandom_range(0, 3);
      d = 1'($urandom);
      n0 = $urandom_range(0, 1);
      run(d, 1'($urandom), nb, n0,
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, nb * BL) : -1,
          16'($urandom_range(1, 65535)), (nb > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bt_pipe_initiator.md
# bt_pipe_initiator

On-chip initiator for the block-throttled pipe user interface. It drives a pipe-in consumer with pattern data, or drains a pipe-out producer and checks what it returns. It lets the pipe checkers be exercised in loopback without a host, and acts as the host-side end of the same handshake. Data is sent in bursts of BLOCK_LEN words, gated only at block boundaries, with the same LFSR/counter patterns the checkers use.

## Interface
- BLOCK_LEN, 64: words per block; power of two, at least 2.
- SEED, 32'h0000_0001: LFSR load value at each start; must be non-zero.
- clk  in  1  single clock; every register is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy.
- dir  in  1  0 = write (drive wr_*), 1 = read (drive rd_*); sampled at start.
- mode  in  1  0 = LFSR pattern, 1 = counter pattern; sampled at start.
- num_blocks  in  16  blocks to transfer; sampled at start.
- busy  out  1  high from the cycle after start until the done pulse.
- done  out  1  one-cycle completion pulse.
- error_count  out  16  read-mode mismatches; saturates; cleared at start.
- block_strobe  out  1  one-cycle pulse before each block.
- wr_write  out  1  write strobe; one word per cycle.
- wr_data  out  16  write data; valid in the same cycle as wr_write.
- wr_ready  in  1  consumer can accept a full block.
- rd_read  out  1  read strobe.
- rd_data  in  16  read data; valid one cycle after rd_read.
- rd_valid  in  1  producer holds a full block.

## Operation
- States:
  - IDLE: on start, go to DONE if num_blocks == 0, otherwise go to WAIT_RDY.
  - WAIT_RDY: stay until the ready input for the selected direction (wr_ready or rd_valid) is sampled high, then go to STROBE.
  - STROBE: assert block_strobe for one cycle, then go to BURST.
  - BURST: issue exactly BLOCK_LEN strobes on consecutive cycles.
    - After the last strobe, if blocks remain, go to WAIT_RDY.
    - Otherwise, in write mode go to DONE; in read mode go to DRAIN.
  - DRAIN: compare the last read word, then go to DONE.
  - DONE: assert done, then go to IDLE.
- Ready is ignored during BURST; throttling happens only at block boundaries.
- Pattern generation:
  - LFSR is 32-bit Fibonacci with polynomial x^32+x^22+x^2+x+1, loaded with SEED at start.
  - Word = lfsr[15:0]; the LFSR advances once per strobe.
  - Counter mode: the first word is 16'h0001, then +1 per word, wrapping 16'hFFFF -> 16'h0000.
- Read check:
  - On the cycle after each rd_read, compare rd_data with the expected word.
  - On mismatch, increment error_count, holding at 16'hFFFF.
- Counters:
  - The block counter is 16-bit and counts down from num_blocks.
  - The word counter is $clog2(BLOCK_LEN) bits and wraps to 0 at the end of each block.
- start while busy has no effect; dir, mode and num_blocks changes are likewise ignored.

## Timing
- Reset values, applied asynchronously:
  - State IDLE; all outputs 0.
  - LFSR = SEED; counter = 0.
  - error_count = 0.
- Reset asserted mid-transfer: strobes drop in the same cycle; no done pulse is generated.
- Write-mode timing from start in cycle 0, with ready already high:
  - Cycle 1: WAIT_RDY, ready sampled high.
  - Cycle 2: block_strobe.
  - Cycles 3 to 2+BLOCK_LEN: wr_write with data.
- Multi-block spacing: with ready continuously high, a block occupies BLOCK_LEN+2 cycles, strobe to strobe.
- Done latency:
  - Write: done one cycle after the last wr_write.
  - Read: done two cycles after the last rd_read.
- num_blocks == 0: done in cycle 1 and no strobes.
- busy is low in the cycle that done is high.

## Structure
- Package bt_pipe_pkg holds:
  - the state enum;
  - LFSR width and tap constants;
  - the counter-mode start value.
- Sub-module pipe_pattern_gen has inputs load, advance and mode, and output word. It is instantiated once:
  - its output drives wr_data in write mode;
  - it supplies the expected word in read mode.

## Test plan
- Counter write, basic:
  - Stimulus: BLOCK_LEN=4, num_blocks=2, mode=1, dir=0, wr_ready held high.
  - Response: wr_data 1,2,3,4, then two idle cycles, then 5,6,7,8; two block_strobe pulses; done one cycle after the 8th write.
- Write throttling:
  - Stimulus: same setup as the basic write, with wr_ready low for 5 cycles after block 1.
  - Response: no strobes while waiting; block 2 resumes with data 5.
- LFSR read:
  - Stimulus: dir=1, mode=0, rd_data from a model driven one cycle after rd_read.
  - Response: error_count 0.
  - Variant: with word 3 XORed with 16'h0001, error_count is 1.
- Empty transfer:
  - Stimulus: num_blocks=0.
  - Response: done at cycle 1; no block_strobe, wr_write or rd_read.
- Reset mid-burst:
  - Stimulus: reset_n low in word 2.
  - Response: all outputs 0 immediately; after restart, the first LFSR word equals SEED[15:0].
- Start while busy:
  - Stimulus: start pulses during BURST.
  - Response: ignored; the strobe count equals num_blocks*BLOCK_LEN and exactly one done pulse occurs.
